// File: rtl/arb_scan_pkg.sv
// Shared types and constants for the four-way round-robin scan arbiter.
package arb_scan_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request scanning from ptr upward, mod 4.
module rr_pick4
  import arb_scan_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] w_cand;

  // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps naturally.
  always_comb begin
    found  = 1'b0;
    idx    = ptr;
    w_cand = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_cand = ptr + IDX_W'(i);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/arb_scan4.sv
// Round-robin arbiter driving a 2-to-4 decoder: registered select, active-low
// enable, minimum grant tenure and a one-cycle break-before-make gap.
module arb_scan4
  import arb_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] sel,
  output logic             enN,
  output logic             busy
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_sel, w_sel_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_holdCnt, w_hold_nxt;
  logic             r_enN, w_enN_nxt;
  logic             r_busy;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic             w_others;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // Any competing request other than the current holder.
  always_comb begin
    w_others = |(req & ~(N_REQ'(1) << r_sel));
  end

  // Next-state, counter and output-register decode.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_holdCnt;
    w_enN_nxt   = r_enN;
    case (r_state)
      IDLE, GAP: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_idx;
          w_hold_nxt  = HOLD_LOAD;
          w_enN_nxt   = 1'b0;
        end else begin
          w_state_nxt = IDLE;
          w_enN_nxt   = 1'b1;
        end
      end
      GRANT: begin
        w_enN_nxt = 1'b0;
        if (r_holdCnt != '0) begin
          w_hold_nxt = r_holdCnt - CNT_W'(1);
        end
        if ((r_holdCnt == '0) && (!req[r_sel] || w_others)) begin
          w_state_nxt = GAP;
          w_ptr_nxt   = r_sel + IDX_W'(1);
          w_enN_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_enN_nxt   = 1'b1;
      end
    endcase
  end

  // State and output registers; reset releases the decoder immediately.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_holdCnt <= '0;
      r_enN     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_holdCnt <= w_hold_nxt;
      r_enN     <= w_enN_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign sel  = r_sel;
  assign enN  = r_enN;
  assign busy = r_busy;

endmodule

// File: tb/tb_arb_scan4.sv
// Bench for arb_scan4: two instances (HOLD_CYCLES 4 and 3) against a
// behavioural model that counts granted cycles and scans requests by rotation.
module tb_arb_scan4;

  logic       clk  = 1'b0;
  logic       rstN = 1'b1;
  logic [3:0] req  = '0;
  logic [1:0] sel_a, sel_b;
  logic       enN_a, enN_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_scan4 #(.HOLD_CYCLES(4)) u_dut (
    .clk(clk), .rstN(rstN), .req(req), .sel(sel_a), .enN(enN_a), .busy(busy_a)
  );

  arb_scan4 #(.HOLD_CYCLES(3)) u_dut3 (
    .clk(clk), .rstN(rstN), .req(req), .sel(sel_b), .enN(enN_b), .busy(busy_b)
  );

  // Reference model, one slot per instance.
  int m_hold[2] = '{4, 3};
  bit m_granted[2];
  bit m_gap[2];
  int m_sel[2];
  int m_ptr[2];
  int m_age[2];

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_granted[d] = 0; m_gap[d] = 0; m_sel[d] = 0; m_ptr[d] = 0; m_age[d] = 0;
    end
  endfunction

  function automatic void model_edge(input int d, input logic [3:0] r);
    logic [3:0] others;
    int k;
    if (m_granted[d]) begin
      m_age[d]++;
      others = r;
      others[m_sel[d]] = 1'b0;
      if (m_age[d] >= m_hold[d] && (!r[m_sel[d]] || others != 4'b0000)) begin
        m_granted[d] = 0;
        m_gap[d]     = 1;
        m_ptr[d]     = (m_sel[d] + 1) % 4;
      end
    end else begin
      k = pick(r, m_ptr[d]);
      m_gap[d] = 0;
      if (k >= 0) begin
        m_granted[d] = 1;
        m_sel[d]     = k;
        m_age[d]     = 0;
      end
    end
  endfunction

  // {busy, enN, sel}
  function automatic logic [3:0] exp_out(input int d);
    logic [1:0] s;
    s = 2'(m_sel[d]);
    return {m_granted[d] | m_gap[d], ~m_granted[d], s};
  endfunction

  function automatic logic [3:0] obs(input int d);
    return (d == 0) ? {busy_a, enN_a, sel_a} : {busy_b, enN_b, sel_b};
  endfunction

  // Apply a request vector for one edge, then settle past the edge.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_edge(0, r);
    model_edge(1, r);
    #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    #2;
    rstN = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs(d) !== 4'b0100) begin
        n_err++;
        $display("FAIL reset_async dut%0d: got %b expected %b", d, obs(d), 4'b0100);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs(0) !== 4'b0100) begin
        n_err++;
        $display("FAIL reset_hold c%0d: got %b expected %b", c, obs(0), 4'b0100);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] r;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      r = (c < 10) ? 4'b0100 : 4'b0000;
      step(r);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== exp_out(d)) begin
          n_err++;
          $display("FAIL single_model dut%0d c%0d: got %b expected %b", d, c, obs(d), exp_out(d));
        end
      end
      if (c < 10) begin
        n_cmp++;
        if ({enN_a, sel_a} !== 3'b010) begin
          n_err++;
          $display("FAIL single_hold c%0d: got enN/sel %b expected %b", c, {enN_a, sel_a}, 3'b010);
        end
      end
      if (c == 10) begin
        n_cmp++;
        if ({busy_a, enN_a} !== 2'b11) begin
          n_err++;
          $display("FAIL single_release: got busy/enN %b expected %b", {busy_a, enN_a}, 2'b11);
        end
      end
      if (c == 11) begin
        n_cmp++;
        if (busy_a !== 1'b0) begin
          n_err++;
          $display("FAIL single_idle: got busy %b expected 0", busy_a);
        end
      end
    end
  endtask

  task automatic test_full_load();
    int q[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic prev_enN;
    int run, gap;
    logic [1:0] run_sel;
    do_reset();
    prev_enN = 1'b1; run = 0; gap = -1; run_sel = '0;
    for (int c = 0; c < 30; c++) begin
      step(4'b1111);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== exp_out(d)) begin
          n_err++;
          $display("FAIL full_model dut%0d c%0d: got %b expected %b", d, c, obs(d), exp_out(d));
        end
      end
      if (enN_a === 1'b0 && prev_enN === 1'b1) begin
        if (gap >= 0) begin
          n_cmp++;
          if (gap != 1) begin
            n_err++;
            $display("FAIL full_gap: got %0d cycles expected 1", gap);
          end
        end
        q.push_back(int'(sel_a));
        run = 1; run_sel = sel_a;
      end else if (enN_a === 1'b0) begin
        run++;
        n_cmp++;
        if (sel_a !== run_sel) begin
          n_err++;
          $display("FAIL full_sel_stable c%0d: got %0d expected %0d", c, sel_a, run_sel);
        end
      end else if (prev_enN === 1'b0) begin
        n_cmp++;
        if (run != 4) begin
          n_err++;
          $display("FAIL full_tenure: got %0d cycles expected 4", run);
        end
        gap = 1;
      end else if (gap >= 0) begin
        gap++;
      end
      prev_enN = enN_a;
    end
    n_cmp++;
    if (q.size() < 5) begin
      n_err++;
      $display("FAIL full_count: got %0d grants expected at least 5", q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (q[i] != exp_order[i]) begin
          n_err++;
          $display("FAIL full_order #%0d: got %0d expected %0d", i, q[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_min_tenure();
    int lows;
    do_reset();
    lows = 0;
    for (int c = 0; c < 8; c++) begin
      step((c == 0) ? 4'b0010 : 4'b0000);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== exp_out(d)) begin
          n_err++;
          $display("FAIL min_model dut%0d c%0d: got %b expected %b", d, c, obs(d), exp_out(d));
        end
      end
      if (enN_a === 1'b0 && sel_a === 2'd1) lows++;
      if (c == 4) begin
        n_cmp++;
        if ({busy_a, enN_a} !== 2'b11) begin
          n_err++;
          $display("FAIL min_gap: got busy/enN %b expected %b", {busy_a, enN_a}, 2'b11);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (busy_a !== 1'b0) begin
          n_err++;
          $display("FAIL min_idle: got busy %b expected 0", busy_a);
        end
      end
    end
    n_cmp++;
    if (lows != 4) begin
      n_err++;
      $display("FAIL min_tenure: got %0d cycles expected 4", lows);
    end
  endtask

  task automatic test_pointer_wrap();
    int q[$];
    int exp_order[3] = '{2, 3, 0};
    logic prev_enN;
    do_reset();
    prev_enN = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step((c == 0) ? 4'b0100 : 4'b1001);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== exp_out(d)) begin
          n_err++;
          $display("FAIL wrap_model dut%0d c%0d: got %b expected %b", d, c, obs(d), exp_out(d));
        end
      end
      if (enN_a === 1'b0 && prev_enN === 1'b1) q.push_back(int'(sel_a));
      prev_enN = enN_a;
    end
    n_cmp++;
    if (q.size() < 3) begin
      n_err++;
      $display("FAIL wrap_count: got %0d grants expected at least 3", q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (q[i] != exp_order[i]) begin
          n_err++;
          $display("FAIL wrap_order #%0d: got %0d expected %0d", i, q[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_async_mid_grant();
    do_reset();
    for (int c = 0; c < 6; c++) step(4'b1111);
    n_cmp++;
    if ({enN_a, sel_a} !== 3'b001) begin
      n_err++;
      $display("FAIL pre_reset_grant: got enN/sel %b expected %b", {enN_a, sel_a}, 3'b001);
    end
    #3;
    rstN = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs(d) !== 4'b0100) begin
        n_err++;
        $display("FAIL async_reset dut%0d: got %b expected %b", d, obs(d), 4'b0100);
      end
    end
    @(posedge clk);
    #1;
    rstN = 1'b1;
    step(4'b0011);
    n_cmp++;
    if ({enN_a, sel_a} !== 3'b000) begin
      n_err++;
      $display("FAIL post_reset_ptr: got enN/sel %b expected %b", {enN_a, sel_a}, 3'b000);
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs(d) !== exp_out(d)) begin
        n_err++;
        $display("FAIL post_reset_model dut%0d: got %b expected %b", d, obs(d), exp_out(d));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      if ($urandom_range(0, 15) == 0) r = '0;
      step(r);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs(d) !== exp_out(d)) begin
          n_err++;
          $display("FAIL random_model dut%0d c%0d req=%b: got %b expected %b", d, c, r, obs(d), exp_out(d));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_load();
    test_min_tenure();
    test_pointer_wrap();
    test_async_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
